// File: rtl/compressor.sv
// Cache-line compressor: picks the cheapest of 8 fixed patterns for a 256-bit line.
// Latency: 1 cycle, registered outputs only; one line accepted every cycle.
// Backpressure: none; en_i low holds data_o/size_o, en_o follows en_i one cycle later.
module compressor #(
   parameter int NUM_PATTERNS = 8,
   parameter int LEN_ENCODE   = $clog2(NUM_PATTERNS)
) (
   input  logic                      clk,
   input  logic                      rst_n,   // active-high synchronous reset (legacy name)
   input  logic [255:0]              data_i,
   input  logic                      en_i,
   output logic [LEN_ENCODE+255:0]   data_o,
   output logic [8:0]                size_o,
   output logic                      en_o
);

   // Codes are shared with the decompressor; do not renumber.
   typedef enum logic [2:0] {
      PAT_ZERO  = 3'd0,
      PAT_REP32 = 3'd1,
      PAT_SX8   = 3'd2,
      PAT_SX16  = 3'd3,
      PAT_BD8   = 3'd4,
      PAT_BD16  = 3'd5,
      PAT_REP64 = 3'd6,
      PAT_RAW   = 3'd7
   } pat_e;

   logic [31:0] w [8];
   logic [31:0] d [1:7];

   logic is_zero, is_rep32, is_sx8, is_sx16, is_bd8, is_bd16, is_rep64;

   pat_e                   code_d;
   logic [255:0]           pay_d;
   logic [8:0]             size_d;

   logic [LEN_ENCODE+255:0] data_q;
   logic [8:0]              size_q;
   logic                    en_q;

   // Split the line into words and form deltas against the base word w0.
   always_comb begin
      for (int k = 0; k < 8; k++) begin
         w[k] = data_i[32*k +: 32];
      end
      for (int k = 1; k < 8; k++) begin
         d[k] = w[k] - w[0];
      end
   end

   // Pattern applicability; a value fits a signed n-bit field when its bits
   // [31:n-1] are all equal.
   always_comb begin
      is_zero  = ~|data_i;
      is_rep32 = 1'b1;
      is_sx8   = 1'b1;
      is_sx16  = 1'b1;
      is_bd8   = 1'b1;
      is_bd16  = 1'b1;
      for (int k = 0; k < 8; k++) begin
         if (w[k] != w[0])                           is_rep32 = 1'b0;
         if (!((&w[k][31:7])  || !(|w[k][31:7])))    is_sx8   = 1'b0;
         if (!((&w[k][31:15]) || !(|w[k][31:15])))   is_sx16  = 1'b0;
      end
      for (int k = 1; k < 8; k++) begin
         if (!((&d[k][31:7])  || !(|d[k][31:7])))    is_bd8   = 1'b0;
         if (!((&d[k][31:15]) || !(|d[k][31:15])))   is_bd16  = 1'b0;
      end
      is_rep64 = (data_i[127:64]  == data_i[63:0]) &&
                 (data_i[191:128] == data_i[63:0]) &&
                 (data_i[255:192] == data_i[63:0]);
   end

   // Fixed priority in ascending compressed size (SX8/REP64 tie goes to SX8).
   always_comb begin
      code_d = PAT_RAW;
      if      (is_zero)  code_d = PAT_ZERO;
      else if (is_rep32) code_d = PAT_REP32;
      else if (is_sx8)   code_d = PAT_SX8;
      else if (is_rep64) code_d = PAT_REP64;
      else if (is_bd8)   code_d = PAT_BD8;
      else if (is_sx16)  code_d = PAT_SX16;
      else if (is_bd16)  code_d = PAT_BD16;
   end

   // Pack the chosen payload from bit 0 upward; everything above stays zero.
   always_comb begin
      pay_d  = '0;
      size_d = 9'd259;
      case (code_d)
         PAT_ZERO: begin
            size_d = 9'd3;
         end
         PAT_REP32: begin
            pay_d[31:0] = w[0];
            size_d      = 9'd35;
         end
         PAT_SX8: begin
            for (int k = 0; k < 8; k++) pay_d[8*k +: 8] = w[k][7:0];
            size_d = 9'd67;
         end
         PAT_SX16: begin
            for (int k = 0; k < 8; k++) pay_d[16*k +: 16] = w[k][15:0];
            size_d = 9'd131;
         end
         PAT_BD8: begin
            pay_d[31:0] = w[0];
            for (int k = 1; k < 8; k++) pay_d[32 + 8*(k-1) +: 8] = d[k][7:0];
            size_d = 9'd91;
         end
         PAT_BD16: begin
            pay_d[31:0] = w[0];
            for (int k = 1; k < 8; k++) pay_d[32 + 16*(k-1) +: 16] = d[k][15:0];
            size_d = 9'd147;
         end
         PAT_REP64: begin
            pay_d[63:0] = data_i[63:0];
            size_d      = 9'd67;
         end
         PAT_RAW: begin
            pay_d  = data_i;
            size_d = 9'd259;
         end
         default: begin
            pay_d  = data_i;
            size_d = 9'd259;
         end
      endcase
   end

   // Output registers: reset wins, results load only on valid input.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         data_q <= '0;
         size_q <= '0;
         en_q   <= 1'b0;
      end else begin
         en_q <= en_i;
         if (en_i) begin
            data_q <= {code_d, pay_d};
            size_q <= size_d;
         end
      end
   end

   assign data_o = data_q;
   assign size_o = size_q;
   assign en_o   = en_q;

endmodule

// File: tb/tb_compressor.sv
// Testbench for compressor: directed pattern lines, then a long random stream
// with random en_i gaps and occasional resets, compared against a reference
// model that picks the smallest applicable encoding by arithmetic range tests.
module tb_compressor;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [255:0] data_i;
   logic         en_i;
   logic [258:0] data_o;
   logic [8:0]   size_o;
   logic         en_o;

   int checks = 0;
   int errors = 0;

   logic [258:0] exp_dat;
   logic [8:0]   exp_sz;
   logic         exp_en;

   localparam int SZ [8] = '{3, 35, 67, 131, 91, 147, 67, 259};

   compressor dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .data_i (data_i),
      .en_i   (en_i),
      .data_o (data_o),
      .size_o (size_o),
      .en_o   (en_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [258:0] obs, input logic [258:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit fits(input int v, input int bits);
      int lo, hi;
      lo = -(1 << (bits - 1));
      hi = (1 << (bits - 1)) - 1;
      return (v >= lo) && (v <= hi);
   endfunction

   // Reference: collect every applicable encoding, choose the smallest size,
   // lowest code on a tie, then lay the payload out field by field.
   function automatic void ref_model(input logic [255:0] l,
                                     output logic [258:0] dat, output logic [8:0] sz);
      logic [31:0] w [8];
      bit          ok [8];
      int          best;
      logic [255:0] p;
      for (int k = 0; k < 8; k++) w[k] = l[32*k +: 32];
      for (int c = 0; c < 8; c++) ok[c] = 1'b1;
      ok[0] = (l == '0);
      for (int k = 0; k < 8; k++) begin
         if (w[k] != w[0])                 ok[1] = 1'b0;
         if (!fits(int'(w[k]), 8))         ok[2] = 1'b0;
         if (!fits(int'(w[k]), 16))        ok[3] = 1'b0;
         if (k > 0 && !fits(int'(w[k] - w[0]), 8))  ok[4] = 1'b0;
         if (k > 0 && !fits(int'(w[k] - w[0]), 16)) ok[5] = 1'b0;
      end
      for (int j = 1; j < 4; j++)
         if (l[64*j +: 64] != l[63:0]) ok[6] = 1'b0;
      best = 7;
      for (int c = 0; c < 8; c++)
         if (ok[c] && SZ[c] < SZ[best]) best = c;
      p = '0;
      case (best)
         1: p[31:0] = w[0];
         2: for (int k = 0; k < 8; k++) p[8*k +: 8] = w[k][7:0];
         3: for (int k = 0; k < 8; k++) p[16*k +: 16] = w[k][15:0];
         4: begin
            p[31:0] = w[0];
            for (int k = 1; k < 8; k++) p[32 + 8*(k-1) +: 8] = 8'(w[k] - w[0]);
         end
         5: begin
            p[31:0] = w[0];
            for (int k = 1; k < 8; k++) p[32 + 16*(k-1) +: 16] = 16'(w[k] - w[0]);
         end
         6: p[63:0] = l[63:0];
         7: p = l;
         default: p = '0;
      endcase
      dat = {3'(best), p};
      sz  = 9'(SZ[best]);
   endfunction

   // One clock: apply inputs, advance the expected registers, check after the edge.
   task automatic cycle(input logic [255:0] l, input logic e, input logic r);
      logic [258:0] md;
      logic [8:0]   ms;
      data_i = l;
      en_i   = e;
      rst_n  = r;
      @(posedge clk);
      if (r) begin
         exp_dat = '0;
         exp_sz  = '0;
         exp_en  = 1'b0;
      end else begin
         exp_en = e;
         if (e) begin
            ref_model(l, md, ms);
            exp_dat = md;
            exp_sz  = ms;
         end
      end
      #1;
      chk("en_o",   259'(en_o),   259'(exp_en));
      chk("data_o", data_o,       exp_dat);
      chk("size_o", 259'(size_o), 259'(exp_sz));
   endtask

   function automatic logic [31:0] sx(input logic [15:0] v, input int bits);
      logic [31:0] r;
      r = 32'(v);
      if (bits == 8) r = {{24{v[7]}}, v[7:0]};
      else           r = {{16{v[15]}}, v[15:0]};
      return r;
   endfunction

   // Line generator biased toward each pattern, including delta edge values.
   function automatic logic [255:0] gen(input int kind);
      logic [255:0] l;
      logic [31:0]  w0;
      logic [63:0]  q;
      w0 = $urandom;
      for (int k = 0; k < 8; k++) l[32*k +: 32] = $urandom;
      case (kind)
         0: l = '0;
         1: for (int k = 0; k < 8; k++) l[32*k +: 32] = w0;
         2: for (int k = 0; k < 8; k++) l[32*k +: 32] = sx(16'($urandom), 8);
         3: for (int k = 0; k < 8; k++) l[32*k +: 32] = sx(16'($urandom), 16);
         4: begin
            l[31:0] = w0;
            for (int k = 1; k < 8; k++) l[32*k +: 32] = w0 + sx(16'($urandom), 8);
         end
         5: begin
            l[31:0] = w0;
            for (int k = 1; k < 8; k++) l[32*k +: 32] = w0 + sx(16'($urandom), 16);
         end
         6: begin
            q = {32'($urandom), 32'($urandom)};
            l = {q, q, q, q};
         end
         7: begin
            l[31:0] = w0;
            for (int k = 1; k < 8; k++) l[32*k +: 32] = w0 + (($urandom_range(0, 1) == 1) ? 32'd127 : 32'hFFFF_FF80);
            if ($urandom_range(0, 1) == 1) l[32*$urandom_range(1, 7) +: 32] = w0 + 32'd128;
            else                           l[32*$urandom_range(1, 7) +: 32] = w0 - 32'd129;
         end
         default: ;
      endcase
      return l;
   endfunction

   initial begin
      logic [255:0] l;
      logic [63:0]  q;

      // Reset held two cycles; outputs must read zero throughout.
      cycle('0, 1'b1, 1'b1);
      cycle('0, 1'b1, 1'b1);
      chk("rst_size", 259'(size_o), 259'd0);

      cycle('0, 1'b1, 1'b0);
      chk("zero_code", 259'(data_o[258:256]), 259'd0);
      chk("zero_size", 259'(size_o), 259'd3);

      for (int k = 0; k < 8; k++) l[32*k +: 32] = 32'hDEADBEEF;
      cycle(l, 1'b1, 1'b0);
      chk("rep32_code", 259'(data_o[258:256]), 259'd1);
      chk("rep32_pay",  259'(data_o[255:0]),   259'hDEADBEEF);
      chk("rep32_size", 259'(size_o),          259'd35);

      for (int k = 0; k < 8; k++) l[32*k +: 32] = 32'(k);
      cycle(l, 1'b1, 1'b0);
      chk("sx8_code", 259'(data_o[258:256]), 259'd2);
      chk("sx8_pay",  259'(data_o[255:0]),   259'h0706050403020100);
      chk("sx8_size", 259'(size_o),          259'd67);

      for (int k = 0; k < 8; k++) l[32*k +: 32] = (k % 2 == 0) ? 32'hFFFFFF80 : 32'h0000007F;
      cycle(l, 1'b1, 1'b0);
      chk("sx8alt_code", 259'(data_o[258:256]), 259'd2);
      chk("sx8alt_pay",  259'(data_o[255:0]),   259'h7F807F807F807F80);

      for (int k = 0; k < 8; k++) l[32*k +: 32] = 32'h12345600 + 32'(3 * k);
      cycle(l, 1'b1, 1'b0);
      chk("bd8_code", 259'(data_o[258:256]), 259'd4);
      chk("bd8_pay",  259'(data_o[255:0]),   259'h15120F0C090603_12345600);
      chk("bd8_size", 259'(size_o),          259'd91);

      l[255:224] = 32'h12345600 + 32'h200;
      cycle(l, 1'b1, 1'b0);
      chk("bd16_code", 259'(data_o[258:256]), 259'd5);
      chk("bd16_size", 259'(size_o),          259'd147);

      q = 64'h0123456789ABCDEF;
      cycle({q, q, q, q}, 1'b1, 1'b0);
      chk("rep64_code", 259'(data_o[258:256]), 259'd6);
      chk("rep64_pay",  259'(data_o[255:0]),   259'h0123456789ABCDEF);
      chk("rep64_size", 259'(size_o),          259'd67);

      l = gen(8);
      cycle(l, 1'b1, 1'b0);
      chk("raw_code", 259'(data_o[258:256]), 259'd7);
      chk("raw_pay",  259'(data_o[255:0]),   259'(l));
      chk("raw_size", 259'(size_o),          259'd259);

      // en_i low: en_o drops, data and size hold the raw result.
      cycle('0, 1'b0, 1'b0);
      chk("hold_en",   259'(en_o),   259'd0);
      chk("hold_pay",  259'(data_o[255:0]), 259'(l));
      chk("hold_size", 259'(size_o), 259'd259);

      // Long stream with random gaps and rare mid-stream resets.
      for (int i = 0; i < 10000; i++) begin
         cycle(gen($urandom_range(0, 8)),
               ($urandom_range(0, 9) != 0),
               ($urandom_range(0, 499) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
